// File: rtl/apb_rr_arbiter_if.sv
// Bundled APB signals around the round-robin arbiter: N core-side ports plus one downstream port.
// The slave modport is the arbiter's own view; the master modport is the surrounding system.
interface apb_rr_arbiter_if #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 4
);
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
    logic [MASTER_PORTS-1:0]           S_PWRITE;
    logic [MASTER_PORTS-1:0]           S_PSELx;
    logic [MASTER_PORTS-1:0]           S_PENABLE;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]           S_PREADY;

    logic [BUS_WIDTH-1:0] M_PADDR;
    logic                 M_PWRITE;
    logic                 M_PSELx;
    logic                 M_PENABLE;
    logic [BUS_WIDTH-1:0] M_PWDATA;
    logic [BUS_WIDTH-1:0] M_PRDATA;
    logic                 M_PREADY;

    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        output S_PRDATA, S_PREADY,
        output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        input  S_PRDATA, S_PREADY,
        input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin APB arbiter/sequencer: one downstream APB master port shared by MASTER_PORTS cores.
// Optional ACCESS timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    apb_rr_arbiter_if.slave         bus,
    output logic [MASTER_PORTS-1:0] grant,
    output logic                    timeout_err
);
    localparam int IW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [IW-1:0]           winner_reg;
    logic [IW-1:0]           last_reg;
    logic [BUS_WIDTH-1:0]    addr_reg;
    logic [BUS_WIDTH-1:0]    wdata_reg;
    logic                    write_reg;
    logic [MASTER_PORTS-1:0] grant_reg;

    logic [IW-1:0]           pick;
    logic                    pick_valid;
    logic                    resp_valid;
    logic [BUS_WIDTH-1:0]    resp_data;
    logic                    tmo_fire;
    logic                    tmo_hit;

    logic [BUS_WIDTH-1:0]    paddr_arr [MASTER_PORTS];
    logic [BUS_WIDTH-1:0]    pwdata_arr [MASTER_PORTS];

    // PENABLE from the cores carries no information: phases are generated here.
    logic unused_penable;
    assign unused_penable = ^bus.S_PENABLE;

    genvar gi;
    generate
        for (gi = 0; gi < MASTER_PORTS; gi++) begin : g_port
            logic hit;
            assign paddr_arr[gi]  = bus.S_PADDR[gi*BUS_WIDTH +: BUS_WIDTH];
            assign pwdata_arr[gi] = bus.S_PWDATA[gi*BUS_WIDTH +: BUS_WIDTH];
            assign hit            = resp_valid && (winner_reg == IW'(gi));
            assign bus.S_PREADY[gi] = hit;
            assign bus.S_PRDATA[gi*BUS_WIDTH +: BUS_WIDTH] = hit ? resp_data : '0;
        end
    endgenerate

    // Scan from the highest offset down so the nearest requester after last_reg wins.
    always_comb begin
        logic [IW-1:0] cidx;
        pick       = last_reg;
        pick_valid = 1'b0;
        cidx       = '0;
        for (int j = MASTER_PORTS - 1; j >= 0; j--) begin
            cidx = IW'((int'(last_reg) + 1 + j) % MASTER_PORTS);
            if (bus.S_PSELx[cidx]) begin
                pick       = cidx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        resp_valid = 1'b0;
        resp_data  = '0;
        tmo_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.M_PREADY) begin
                    resp_valid = 1'b1;
                    resp_data  = bus.M_PRDATA;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    resp_valid = 1'b1;
                    resp_data  = '1;
                    tmo_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            winner_reg <= '0;
            last_reg   <= IW'(MASTER_PORTS - 1);
            addr_reg   <= '0;
            wdata_reg  <= '0;
            write_reg  <= 1'b0;
            grant_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && pick_valid) begin
                winner_reg <= pick;
                addr_reg   <= paddr_arr[pick];
                wdata_reg  <= pwdata_arr[pick];
                write_reg  <= bus.S_PWRITE[pick];
                grant_reg  <= MASTER_PORTS'(1) << pick;
            end
            if (resp_valid) begin
                last_reg  <= winner_reg;
                grant_reg <= '0;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

    logic [TW-1:0] wait_cnt_reg;

    // Counts ACCESS wait cycles; the response is forced once TIMEOUT waits have elapsed.
    assign tmo_hit = (wait_cnt_reg == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !bus.M_PREADY && !tmo_hit) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo_hit = 1'b0;
`endif

    assign timeout_err   = tmo_fire;
    assign grant         = grant_reg;
    assign bus.M_PADDR   = addr_reg;
    assign bus.M_PWDATA  = wdata_reg;
    assign bus.M_PWRITE  = write_reg;
    assign bus.M_PSELx   = (state_reg != IDLE);
    assign bus.M_PENABLE = (state_reg == ACCESS);
endmodule
